// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_stage_lsu_if : request/response and DataMemory signals of the MEM LSU   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface mem_stage_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_MemOp;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_read;
  logic        req_write;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport slave (
    input  req_valid, req_MemOp, req_addr, req_wdata, req_read, req_write, ReadData,
    output req_ready, rsp_valid, rsp_rdata, misalign_err,
    output MemOp, addr, WriteData, MemRead, MemWrite
  );

  modport master (
    output req_valid, req_MemOp, req_addr, req_wdata, req_read, req_write, ReadData,
    input  req_ready, rsp_valid, rsp_rdata, misalign_err,
    input  MemOp, addr, WriteData, MemRead, MemWrite
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_stage_lsu : MEM-stage load/store unit, splits misaligned accesses       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mem_stage_lsu #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_HI   = 2'd1,
    ST_BYTE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_buf_q, lo_buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_q, err_d;

  logic        is_store, is_load, misaligned;
  logic [1:0]  req_sm1;
  logic [31:0] ld_shifted;

  // Access size minus one: 0 = byte, 1 = half, 3 = word.
  function automatic logic [1:0] size_m1(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] v);
    case (op)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign is_store   = bus.req_write;
  assign is_load    = bus.req_read & ~bus.req_write;
  assign req_sm1    = size_m1(bus.req_MemOp);
  assign misaligned = ((req_sm1 == 2'd1) && bus.req_addr[0]) ||
                      ((req_sm1 == 2'd3) && (bus.req_addr[1:0] != 2'b00));

  // Window of the two captured words starting at the original byte offset.
  always_comb begin
    case (addr_q[1:0])
      2'b01:   ld_shifted = {bus.ReadData[7:0],  lo_buf_q[31:8]};
      2'b10:   ld_shifted = {bus.ReadData[15:0], lo_buf_q[31:16]};
      2'b11:   ld_shifted = {bus.ReadData[23:0], lo_buf_q[31:24]};
      default: ld_shifted = lo_buf_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lo_buf_d      = lo_buf_q;
    rdata_d       = rdata_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    err_d         = 1'b0;
    bus.req_ready = 1'b0;
    bus.MemOp     = 3'b000;
    bus.addr      = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;

    // Memory ports stay quiet while reset is held, even mid-split.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            if (!misaligned) begin
              bus.MemOp     = bus.req_MemOp;
              bus.addr      = bus.req_addr;
              bus.WriteData = bus.req_wdata;
              bus.MemRead   = is_load;
              bus.MemWrite  = is_store;
              rsp_valid_d   = 1'b1;
              rdata_d       = is_load ? bus.ReadData : 32'h0;
            end else if (!SPLIT_EN) begin
              err_d = 1'b1;
            end else if (is_store) begin
              bus.MemOp     = 3'b000;
              bus.addr      = bus.req_addr;
              bus.WriteData = {24'h0, bus.req_wdata[7:0]};
              bus.MemWrite  = 1'b1;
              addr_d        = bus.req_addr;
              wdata_d       = bus.req_wdata;
              op_d          = bus.req_MemOp;
              cnt_d         = 2'd1;
              state_d       = ST_BYTE;
            end else if (is_load) begin
              bus.MemOp     = 3'b010;
              bus.addr      = {bus.req_addr[31:2], 2'b00};
              bus.MemRead   = 1'b1;
              lo_buf_d      = bus.ReadData;
              addr_d        = bus.req_addr;
              op_d          = bus.req_MemOp;
              state_d       = LD_HI;
            end else begin
              rsp_valid_d = 1'b1;
              rdata_d     = 32'h0;
            end
          end
        end

        LD_HI: begin
          bus.MemOp   = 3'b010;
          bus.addr    = {addr_q[31:2], 2'b00} + 32'd4;
          bus.MemRead = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = extend(op_q, ld_shifted);
          state_d     = IDLE;
        end

        ST_BYTE: begin
          bus.MemOp     = 3'b000;
          bus.addr      = addr_q + {30'h0, cnt_q};
          bus.WriteData = wdata_q >> {cnt_q, 3'b000};
          bus.MemWrite  = 1'b1;
          if (cnt_q == size_m1(op_q)) begin
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      lo_buf_q    <= 32'h0;
      rdata_q     <= 32'h0;
      op_q        <= 3'b000;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.misalign_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_stage_lsu : randomized bench for mem_stage_lsu with byte-array model |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if bus ();
  mem_stage_lsu_if bus_ns ();

  mem_stage_lsu #(.SPLIT_EN(1'b1)) u_dut    (.clk(clk), .rst(rst), .bus(bus.slave));
  mem_stage_lsu #(.SPLIT_EN(1'b0)) u_dut_ns (.clk(clk), .rst(rst), .bus(bus_ns.slave));

  assign bus_ns.ReadData = 32'h1234_5678;

  // DataMemory: 256-byte window, combinational extended read, write on clk edge.
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [7:0]  rb0, rb1, rb2, rb3;
  logic [31:0] wlog [64];
  int          wcnt = 0;

  always_comb begin
    rb0 = mem[bus.addr[7:0]];
    rb1 = mem[bus.addr[7:0] + 8'd1];
    rb2 = mem[bus.addr[7:0] + 8'd2];
    rb3 = mem[bus.addr[7:0] + 8'd3];
    case (bus.MemOp)
      3'b000:  bus.ReadData = {{24{rb0[7]}}, rb0};
      3'b100:  bus.ReadData = {24'h0, rb0};
      3'b001:  bus.ReadData = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  bus.ReadData = {16'h0, rb1, rb0};
      default: bus.ReadData = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      mem[bus.addr[7:0]] <= bus.WriteData[7:0];
      if (bus.MemOp[1:0] != 2'b00) mem[bus.addr[7:0] + 8'd1] <= bus.WriteData[15:8];
      if (bus.MemOp[1] || bus.MemOp[1:0] == 2'b11) begin
        mem[bus.addr[7:0] + 8'd2] <= bus.WriteData[23:16];
        mem[bus.addr[7:0] + 8'd3] <= bus.WriteData[31:24];
      end
      wlog[wcnt[5:0]] <= bus.addr;
      wcnt            <= wcnt + 1;
    end
  end

  // Reference model: architectural byte memory and access rules.
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  function automatic int size_of(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < size_of(op); i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
    if (op == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_of(op); i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, output logic [31:0] got);
    int          n, lat_exp, lat, stall;
    bit          mis, seen;
    logic [31:0] exp_rd;
    n       = size_of(op);
    mis     = (a % 32'(n)) != 0;
    lat_exp = !mis ? 1 : (wr ? n : 2);
    exp_rd  = wr ? 32'h0 : ref_load(op, a);
    @(negedge clk);
    check_eq("idle_mem_quiet", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    check_eq("idle_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b1;
    bus.req_MemOp = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_read  = rd;
    bus.req_write = wr;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    lat   = 0;
    stall = 0;
    seen  = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      lat = c;
      if (bus.rsp_valid) seen = 1'b1;
      else if (!bus.req_ready) stall++;
    end
    check_eq("rsp_seen", 32'(seen), 32'h1);
    check_eq("latency", 32'(lat), 32'(lat_exp));
    check_eq("stall_cycles", 32'(stall), 32'(lat_exp - 1));
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_eq("no_err", 32'(bus.misalign_err), 32'h0);
    got = bus.rsp_rdata;
    if (wr) ref_store(op, a, wd);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] got, a, wd;
    logic [2:0]  op;
    logic        rd, wr;
    int          w0, kind;

    bus.req_valid = 1'b0; bus.req_MemOp = 3'b000; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus_ns.req_valid = 1'b0; bus_ns.req_MemOp = 3'b000; bus_ns.req_addr = 32'h0;
    bus_ns.req_wdata = 32'h0; bus_ns.req_read = 1'b0; bus_ns.req_write = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(bus.misalign_err), 32'h0);
    check_eq("rst_mem_quiet", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned store/load round trip.
    do_req(3'b010, 32'h8, 32'hdead_beef, 1'b0, 1'b1, got);
    do_req(3'b010, 32'h8, 32'h0, 1'b1, 1'b0, got);
    check_eq("t1_lw", got, 32'hdead_beef);

    // Misaligned loads across a word boundary.
    do_req(3'b010, 32'h0, 32'h4433_2211, 1'b0, 1'b1, got);
    do_req(3'b010, 32'h4, 32'h8877_6655, 1'b0, 1'b1, got);
    do_req(3'b010, 32'h1, 32'h0, 1'b1, 1'b0, got);
    check_eq("t2_lw_1", got, 32'h5544_3322);
    do_req(3'b001, 32'h3, 32'h0, 1'b1, 1'b0, got);
    check_eq("t3_lh_3", got, 32'h0000_5544);
    do_req(3'b001, 32'h7, 32'h0, 1'b1, 1'b0, got);
    check_eq("t3_lh_7", got, 32'hffff_ef88);
    do_req(3'b101, 32'h7, 32'h0, 1'b1, 1'b0, got);
    check_eq("t3_lhu_7", got, 32'h0000_ef88);
    do_req(3'b101, 32'h6, 32'h0, 1'b1, 1'b0, got);
    check_eq("t3_lhu_6", got, 32'h0000_8877);

    // Misaligned word store split into four byte writes.
    do_req(3'b010, 32'h2, 32'haabb_ccdd, 1'b0, 1'b1, got);
    do_req(3'b010, 32'h0, 32'h0, 1'b1, 1'b0, got);
    check_eq("t4_lw_0", got, 32'hccdd_2211);
    do_req(3'b010, 32'h4, 32'h0, 1'b1, 1'b0, got);
    check_eq("t4_lw_4", got, 32'h8877_aabb);

    // Split store wrapping past the top of the address space.
    w0 = wcnt;
    do_req(3'b010, 32'hffff_fffe, 32'h0102_0304, 1'b0, 1'b1, got);
    check_eq("t5_nwrites", 32'(wcnt - w0), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("t5_wr_addr", wlog[6'(w0 + i)], 32'hffff_fffe + 32'(i));
    do_req(3'b010, 32'h0, 32'h0, 1'b1, 1'b0, got);

    // Reset during a split store after two bytes.
    @(negedge clk);
    w0 = wcnt;
    bus.req_valid = 1'b1; bus.req_MemOp = 3'b010; bus.req_addr = 32'h21;
    bus.req_wdata = 32'h1122_3344; bus.req_read = 1'b0; bus.req_write = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_mw_off", 32'(bus.MemWrite), 32'h0);
    check_eq("t6_rsp_off", 32'(bus.rsp_valid), 32'h0);
    ref_store(3'b001, 32'h21, 32'h0000_3344);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_ready", 32'(bus.req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_nwrites", 32'(wcnt - w0), 32'd2);
    do_req(3'b010, 32'h20, 32'h0, 1'b1, 1'b0, got);
    do_req(3'b010, 32'h24, 32'h0, 1'b1, 1'b0, got);

    // SPLIT_EN=0 instance: misaligned dropped, aligned still served.
    @(negedge clk);
    bus_ns.req_valid = 1'b1; bus_ns.req_MemOp = 3'b010; bus_ns.req_addr = 32'h1;
    bus_ns.req_read = 1'b1; bus_ns.req_write = 1'b0;
    #1;
    check_eq("ns_no_mr", 32'(bus_ns.MemRead), 32'h0);
    check_eq("ns_ready", 32'(bus_ns.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus_ns.req_valid = 1'b0; bus_ns.req_read = 1'b0;
    check_eq("ns_err", 32'(bus_ns.misalign_err), 32'h1);
    check_eq("ns_no_rsp", 32'(bus_ns.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    check_eq("ns_err_pulse", 32'(bus_ns.misalign_err), 32'h0);
    @(negedge clk);
    bus_ns.req_valid = 1'b1; bus_ns.req_addr = 32'h4; bus_ns.req_read = 1'b1;
    @(posedge clk);
    #1;
    bus_ns.req_valid = 1'b0; bus_ns.req_read = 1'b0;
    check_eq("ns_al_rsp", 32'(bus_ns.rsp_valid), 32'h1);
    check_eq("ns_al_rdata", bus_ns.rsp_rdata, 32'h1234_5678);
    check_eq("ns_al_err", 32'(bus_ns.misalign_err), 32'h0);

    // Randomized mix of loads and stores against the byte model.
    for (int k = 0; k < 80; k++) begin
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      if (wr) begin
        case ($urandom_range(0, 2))
          0:       op = 3'b000;
          1:       op = 3'b001;
          default: op = 3'b010;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0:       op = 3'b000;
          1:       op = 3'b001;
          2:       op = 3'b010;
          3:       op = 3'b100;
          default: op = 3'b101;
        endcase
      end
      if ($urandom_range(0, 7) == 0) a = 32'hffff_fff8 + 32'($urandom_range(0, 7));
      else                           a = 32'($urandom_range(0, 47));
      wd = $urandom;
      do_req(op, a, wd, rd, wr, got);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
